// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath.
package mips_pkg;

  localparam int unsigned XLen = 32;
  localparam logic [XLen-1:0] ResetPc = 32'h0000_0000;

  // ALU operation codes driven on alucontrol.
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU B-operand select.
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcHold   = 2'b11;

  // Opcodes seen on op.
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  function automatic logic [XLen-1:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero; reads during a write see the old contents.
module regfile
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  input  logic [4:0]      i_wa,
  input  logic            i_we,
  input  logic [XLen-1:0] i_wd,
  output logic [XLen-1:0] o_rd1,
  output logic [XLen-1:0] o_rd2
);

  logic [XLen-1:0] r_regs [32];

  // Synchronous clear on reset, otherwise write when enabled and not targeting $0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Combinational reads with $0 forced to zero.
  always_comb begin
    o_rd1 = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
    o_rd2 = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and muxes.
module mc_datapath
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            pcen,
  input  logic            irwrite,
  input  logic            regwrite,
  input  logic            alusrca,
  input  logic            iord,
  input  logic            memtoreg,
  input  logic            regdst,
  input  logic [1:0]      alusrcb,
  input  logic [1:0]      pcsrc,
  input  logic [2:0]      alucontrol,
  input  logic [XLen-1:0] readdata,
  output logic [XLen-1:0] adr,
  output logic [XLen-1:0] writedata,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic            zero
);

  logic [XLen-1:0] r_pc;
  logic [XLen-1:0] r_ir;
  logic [XLen-1:0] r_mdr;
  logic [XLen-1:0] r_a;
  logic [XLen-1:0] r_b;
  logic [XLen-1:0] r_aluout;

  logic [XLen-1:0] w_rd1;
  logic [XLen-1:0] w_rd2;
  logic [XLen-1:0] w_signimm;
  logic [XLen-1:0] w_srca;
  logic [XLen-1:0] w_srcb;
  logic [XLen-1:0] w_alu_result;
  logic [XLen-1:0] w_pcnext;
  logic [4:0]      w_wa;
  logic [XLen-1:0] w_wd;

  // Architectural state; IR samples readdata addressed by the pre-edge PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= ResetPc;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (pcen) begin
        r_pc <= w_pcnext;
      end
      if (irwrite) begin
        r_ir <= readdata;
      end
      r_mdr    <= readdata;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu_result;
    end
  end

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .i_ra1 (r_ir[25:21]),
    .i_ra2 (r_ir[20:16]),
    .i_wa  (w_wa),
    .i_we  (regwrite),
    .i_wd  (w_wd),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Operand selection and sign extension.
  always_comb begin
    w_signimm = sign_ext16(r_ir[15:0]);
    w_srca    = alusrca ? r_a : r_pc;
    w_srcb    = r_b;
    case (alusrcb)
      SrcBReg:   w_srcb = r_b;
      SrcBFour:  w_srcb = 32'd4;
      SrcBImm:   w_srcb = w_signimm;
      SrcBImmSh: w_srcb = {w_signimm[XLen-3:0], 2'b00};
      default:   w_srcb = r_b;
    endcase
  end

  // ALU; unlisted codes produce zero, carries wrap.
  always_comb begin
    w_alu_result = '0;
    case (alucontrol)
      AluAdd:  w_alu_result = w_srca + w_srcb;
      AluSub:  w_alu_result = w_srca - w_srcb;
      AluAnd:  w_alu_result = w_srca & w_srcb;
      AluOr:   w_alu_result = w_srca | w_srcb;
      AluSlt:  w_alu_result = {31'b0, ($signed(w_srca) < $signed(w_srcb))};
      default: w_alu_result = '0;
    endcase
  end

  // Next-PC selection and register-file write path.
  always_comb begin
    w_pcnext = r_pc;
    case (pcsrc)
      PcAlu:    w_pcnext = w_alu_result;
      PcAluOut: w_pcnext = r_aluout;
      PcJump:   w_pcnext = {r_pc[31:28], r_ir[25:0], 2'b00};
      PcHold:   w_pcnext = r_pc;
      default:  w_pcnext = r_pc;
    endcase
    w_wa = regdst ? r_ir[15:11] : r_ir[20:16];
    w_wd = memtoreg ? r_mdr : r_aluout;
  end

  // Memory interface and controller feedback.
  always_comb begin
    adr       = iord ? r_aluout : r_pc;
    writedata = r_b;
    op        = r_ir[31:26];
    funct     = r_ir[5:0];
    zero      = (w_alu_result == '0);
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst  in  1 each  controller strobes and selects.
REQ-005 alusrcb, pcsrc  in  2 each  ALU B-operand select and next-PC select.
REQ-006 alucontrol  in  3  ALU operation.
REQ-007 readdata  in  32  memory read data, valid in the same cycle as adr.
REQ-008 adr, writedata  out  32 each  memory address and store data.
REQ-009 op, funct  out  6 each  IR[31:26] and IR[5:0], fed back to the controller.
REQ-010 zero  out  1  high when the combinational ALU result equals 0.

Function
REQ-011 The datapath SHALL hold these registers: PC, IR, MDR, A, B, ALUOut.
- PC loads only when pcen=1.
- IR loads readdata only when irwrite=1.
- MDR, A, B and ALUOut load every cycle.
REQ-012 adr SHALL equal PC when iord=0 and ALUOut when iord=1; writedata SHALL equal B.
REQ-013 ALU A operand SHALL be PC when alusrca=0 and A when alusrca=1.
REQ-014 ALU B operand SHALL be selected by alusrcb:
- 00: B
- 01: 32'd4
- 10: SignImm (sign-extended IR[15:0])
- 11: SignImm<<2
REQ-015 ALU operation SHALL be selected by alucontrol:
- 010 add, 110 sub, 000 and, 001 or, 111 slt (result 1 if signed A<B, else 0).
- Any other code yields 0.
- Arithmetic is 32-bit; carry out is discarded (wrap-around).
REQ-016 Next PC SHALL be selected by pcsrc:
- 00: ALU result
- 01: ALUOut
- 10: {PC[31:28], IR[25:0], 2'b00}
- 11: PC (hold)
REQ-017 Register file SHALL have 32 x 32-bit registers with two combinational read ports (IR[25:21]->A input, IR[20:16]->B input) and one synchronous write port.
REQ-018 Write address SHALL be IR[15:11] when regdst=1 and IR[20:16] when regdst=0.
REQ-019 Write data SHALL be MDR when memtoreg=1 and ALUOut when memtoreg=0.
REQ-020 Writes SHALL occur only when regwrite=1; writes to register 0 SHALL be ignored, and register 0 SHALL always read 0.
REQ-021 Read and write of the same register in one cycle SHALL return the old value in that cycle (no bypass); the new value is visible from the next cycle.
REQ-022 op, funct and zero SHALL be combinational from IR and the ALU result, with no added latency.
REQ-023 When pcen and irwrite are both high in one cycle, IR SHALL capture readdata addressed by the old PC.

Reset
REQ-024 On reset=1 at a clock edge:
- PC <= RESET_PC.
- IR, MDR, A, B, ALUOut and all 32 registers <= 0.
REQ-025 Consequently op=0, funct=0 and adr=RESET_PC in the cycle after reset.
REQ-026 Reset SHALL take priority over pcen, irwrite and regwrite asserted in the same cycle, including mid-instruction.

Structure
REQ-027 A shared package mips_pkg SHALL hold:
- alucontrol codes
- alusrcb and pcsrc encodings
- opcode constants (RTYPE 00, LW 23, SW 2b, BEQ 04, ADDI 08, J 02)
REQ-028 The register file SHALL be one sub-module, regfile; the ALU, muxes and sign-extend stay inline.

Verification
REQ-029 Reset held 2 cycles, then released -> adr=0, op=0, funct=0, PC=0.
REQ-030 Fetch: readdata=32'h2002_0005 (addi $2,$0,5), irwrite=1, pcen=1, alusrcb=01, pcsrc=00 -> PC=4, op=08.
- Then execute (alusrca=1, alusrcb=10, add), then writeback (regwrite=1, regdst=0, memtoreg=0) -> $2=5.
REQ-031 R-type sub $3,$2,$2 -> zero=1 during execute; $3=0 after writeback.
- slt with $2=5, $4=-1 -> result 0.
REQ-032 beq: pcsrc=01 with ALUOut=PC+4+(SignImm<<2) computed in decode, pcen=1 -> PC jumps to the target.
- With pcen=0 -> PC is unchanged.
REQ-033 j: IR=32'h0800_0010, pcsrc=10, pcen=1 -> PC=32'h0000_0040.
REQ-034 lw with iord=1, readdata=32'hDEAD_BEEF, then memtoreg=1, regwrite=1 -> rt=32'hDEAD_BEEF.
- Same writeback targeting $0 -> $0 still reads 0.
